// File: rtl/nibble_serial_add_sub_if.sv
// Operand/result handshake bundle for the nibble-serial add/subtract engine.
// master drives operands and accepts results; slave is the engine itself.
interface nibble_serial_add_sub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, busy
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, busy
    );
endinterface

// File: rtl/nibble_serial_add_sub.sv
// WIDTH-bit add/subtract built from one 4-bit slice, stepped one nibble per clock
// with the carry chained between nibbles. Subtract is A + ~B + 1.
module nibble_serial_add_sub #(
    parameter int unsigned WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    nibble_serial_add_sub_if.slave bus
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic             mode_q, mode_d, cin_q, cin_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [3:0] nib_a, nib_b;
    logic [3:0] lo_sum;
    logic [4:0] full_sum;
    logic       c_out, c_msb;

    // The 4-bit slice: current nibble pair plus chained carry.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4] ^ {4{mode_q}};
            end
        end
        lo_sum   = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, cin_q};
        full_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, cin_q};
        c_out    = full_sum[4];
        c_msb    = lo_sum[3];  // carry into bit 3 of this nibble
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        cin_d    = cin_q;
        idx_d    = idx_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    mode_d   = bus.mode;
                    cin_d    = bus.mode;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                for (int unsigned i = 0; i < NIB; i++) begin
                    if (idx_q == IDXW'(i)) result_d[4*i +: 4] = full_sum[3:0];
                end
                cin_d = c_out;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NIB - 1)) begin
                    carry_d = c_out;
                    ovf_d   = c_out ^ c_msb;
                    zero_d  = (result_d == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            cin_q    <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            cin_q    <= cin_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q == StRun);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule
